// File: rtl/alu_datamem_seq_pkg.sv
// ============================================================================
// Module  : dp_pkg
// Purpose : Shared types for the sequenced ALU / data-memory datapath.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dp_pkg;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SLL = 4'd5,
      ALU_SRL = 4'd6,
      ALU_SLT = 4'd7,
      ALU_BEQ = 4'd8,
      ALU_BNE = 4'd9
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_EXEC = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4
   } dp_state_e;

   // Control part of a captured micro-op; the WIDTH/RA-sized fields are
   // held alongside it in the top level.
   typedef struct packed {
      alu_op_e aluop;
      logic    alusrc1;
      logic    alusrc2;
      logic    regwrite;
      logic    memwrite;
      logic    memtoreg;
   } micro_op_t;

   function automatic logic needs_mem(input micro_op_t op);
      return op.memwrite | op.memtoreg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_datamem_seq_alu.sv
// ============================================================================
// Module  : dp_alu
// Purpose : Combinational ALU with signed overflow and branch-compare flags.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dp_alu
   import dp_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  alu_op_e          op_i,
   output logic [WIDTH-1:0] f_o,
   output logic             ovf_o,
   output logic             take_branch_o
);

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [SHW-1:0]   shamt;

   assign sum   = a_i + b_i;
   assign diff  = a_i - b_i;
   assign shamt = b_i[SHW-1:0];

   always_comb begin
      f_o           = '0;
      ovf_o         = 1'b0;
      take_branch_o = 1'b0;
      case (op_i)
         ALU_ADD: begin
            f_o   = sum;
            ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
         end
         ALU_SUB: begin
            f_o   = diff;
            ovf_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
         end
         ALU_AND: f_o = a_i & b_i;
         ALU_OR:  f_o = a_i | b_i;
         ALU_XOR: f_o = a_i ^ b_i;
         ALU_SLL: f_o = a_i << shamt;
         ALU_SRL: f_o = a_i >> shamt;
         ALU_SLT: f_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         ALU_BEQ: take_branch_o = (a_i == b_i);
         ALU_BNE: take_branch_o = (a_i != b_i);
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_datamem_seq.sv
// ============================================================================
// Module  : alu_datamem_seq
// Purpose : Multi-cycle register file / ALU / data-memory datapath, one
//           micro-op per handshake, result reported with a res_valid pulse.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_datamem_seq
   import dp_pkg::*;
#(
   parameter  int WIDTH     = 16,
   parameter  int NREGS     = 8,
   parameter  int MEM_DEPTH = 256,
   localparam int RA        = $clog2(NREGS),
   localparam int MA        = $clog2(MEM_DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [3:0]       op_aluop,
   input  logic             op_alusrc1,
   input  logic             op_alusrc2,
   input  logic [WIDTH-1:0] op_imm,
   input  logic             op_regwrite,
   input  logic             op_memwrite,
   input  logic             op_memtoreg,
   input  logic [RA-1:0]    op_rs1,
   input  logic [RA-1:0]    op_rs2,
   input  logic [RA-1:0]    op_rd,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic             res_ovf,
   output logic             res_take_branch,
   output logic             ovf_sticky,
   input  logic             clr_sticky
);

   dp_state_e        state_q, state_d;
   micro_op_t        op_q;
   logic [WIDTH-1:0] imm_q;
   logic [RA-1:0]    rs1_q, rs2_q, rd_q;
   logic [WIDTH-1:0] a_q, b_q, sd_q, alu_q;
   logic             ovf_q, br_q;
   logic [WIDTH-1:0] res_q;
   logic             res_ovf_q, res_br_q, sticky_q;
   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] mem_q  [MEM_DEPTH];

   logic [WIDTH-1:0] alu_f;
   logic             alu_ovf, alu_br;
   logic [MA-1:0]    mem_addr;
   logic             accept;

   assign op_ready        = (state_q == ST_IDLE);
   assign accept          = op_valid & op_ready;
   assign res_valid       = (state_q == ST_WB);
   assign res_data        = res_q;
   assign res_ovf         = res_ovf_q;
   assign res_take_branch = res_br_q;
   assign ovf_sticky      = sticky_q;
   assign mem_addr        = alu_q[MA-1:0];

   dp_alu #(.WIDTH(WIDTH)) u_alu (
      .a_i           (a_q),
      .b_i           (b_q),
      .op_i          (op_q.aluop),
      .f_o           (alu_f),
      .ovf_o         (alu_ovf),
      .take_branch_o (alu_br)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_READ;
         ST_READ: state_d = ST_EXEC;
         ST_EXEC: state_d = needs_mem(op_q) ? ST_MEM : ST_WB;
         ST_MEM:  state_d = ST_WB;
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         imm_q     <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         sd_q      <= '0;
         alu_q     <= '0;
         ovf_q     <= 1'b0;
         br_q      <= 1'b0;
         res_q     <= '0;
         res_ovf_q <= 1'b0;
         res_br_q  <= 1'b0;
         sticky_q  <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: if (accept) begin
               op_q  <= '{aluop:    alu_op_e'(op_aluop),
                          alusrc1:  op_alusrc1,
                          alusrc2:  op_alusrc2,
                          regwrite: op_regwrite,
                          memwrite: op_memwrite,
                          memtoreg: op_memtoreg};
               imm_q <= op_imm;
               rs1_q <= op_rs1;
               rs2_q <= op_rs2;
               rd_q  <= op_rd;
            end
            ST_READ: begin
               a_q  <= op_q.alusrc1 ? '0 : regs_q[rs1_q];
               b_q  <= op_q.alusrc2 ? imm_q : regs_q[rs2_q];
               sd_q <= regs_q[rs2_q];
            end
            ST_EXEC: begin
               alu_q <= alu_f;
               ovf_q <= alu_ovf;
               br_q  <= alu_br;
               // Non-memory ops go straight to WB, so publish the result now.
               if (!needs_mem(op_q)) begin
                  res_q     <= alu_f;
                  res_ovf_q <= alu_ovf;
                  res_br_q  <= alu_br;
               end
            end
            ST_MEM: begin
               // Reads the pre-store word: the array update lands on this same edge.
               res_q     <= op_q.memtoreg ? mem_q[mem_addr] : alu_q;
               res_ovf_q <= ovf_q;
               res_br_q  <= br_q;
            end
            ST_WB: if (op_q.regwrite) regs_q[rd_q] <= res_q;
            default: ;
         endcase
         if ((state_q == ST_WB) && res_ovf_q) sticky_q <= 1'b1;
         else if (clr_sticky)                 sticky_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if ((state_q == ST_MEM) && op_q.memwrite) mem_q[mem_addr] <= sd_q;
   end

endmodule

`default_nettype wire

// File: doc/alu_datamem_seq.md
# alu_datamem_seq

Parametrised, multi-cycle successor to the lab ALU/data-memory datapath. It holds a register file, two operand muxes, an ALU and a synchronous data memory behind a sequencing FSM. The FSM accepts one decoded micro-op per valid/ready handshake, executes it in 4 or 5 cycles and reports the result with a one-cycle `res_valid` pulse. It sits between a micro-op source (VIO or a future decoder) and the display adaptor, which consumes `res_data`.

## Interface
Parameters:
- `WIDTH`, 16, datapath width in bits (≥ 8).
- `NREGS`, 8, register count (power of 2); `RA = $clog2(NREGS)`.
- `MEM_DEPTH`, 256, data-memory words (power of 2); `MA = $clog2(MEM_DEPTH)`.

Ports:
- `clk`  in  1  system clock, all state on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  micro-op present.
- `op_ready`  out  1  block can accept a micro-op (high only in IDLE).
- `op_aluop`  in  4  ALU operation (alu_op_e).
- `op_alusrc1`  in  1  1: ALU A = 0; 0: A = R[rs1].
- `op_alusrc2`  in  1  1: ALU B = `op_imm`; 0: B = R[rs2].
- `op_imm`  in  WIDTH  immediate.
- `op_regwrite`, `op_memwrite`, `op_memtoreg`  in  1 each  write enables / writeback select.
- `op_rs1`, `op_rs2`, `op_rd`  in  RA each  register addresses.
- `res_valid`  out  1  one-cycle completion pulse.
- `res_data`  out  WIDTH  writeback value (ALU result or loaded word).
- `res_ovf`, `res_take_branch`  out  1 each  flags of the completed op; valid with `res_valid`.
- `ovf_sticky`  out  1  set by any completed op with ovf.
- `clr_sticky`  in  1  clears `ovf_sticky`.

## Operation
- **Capture.** On `op_valid & op_ready`, all `op_*` fields are captured into an internal op register. Inputs are ignored at all other times.
- **FSM states:** IDLE → READ → EXEC → (MEM if memwrite|memtoreg) → WB → IDLE.
- **READ.** Registers operand A (0 or R[rs1]) and operand B (imm or R[rs2]), plus store data R[rs2].
- **EXEC.** Registers the ALU result, ovf and take_branch.
- **ALU ops:**
  - 0 ADD, 1 SUB: ovf = signed two's-complement overflow.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL: shift A by B[$clog2(WIDTH)-1:0].
  - 7 SLT: signed compare, result 1/0.
  - 8 BEQ, 9 BNE: result 0; take_branch = (A==B) / (A!=B).
  - 10–15: result 0, flags 0.
  - ovf is 0 for every op except ADD/SUB. Results truncate to WIDTH.
- **MEM.** The memory address is alu_result[MA-1:0]; upper bits are ignored, so addresses wrap. A store writes on the edge leaving MEM. A load registers the read data on the same edge. If both memwrite and memtoreg are set, the load returns the old word (read-first).
- **WB.**
  - `res_valid` = 1 for this cycle only.
  - `res_data` = memtoreg ? loaded word : ALU result.
  - If regwrite, R[rd] ← res_data on the edge leaving WB.
  - `res_data`, `res_ovf` and `res_take_branch` hold their values until the next WB.
- **Sticky flag.** `ovf_sticky` is set in WB when res_ovf = 1 and cleared by `clr_sticky`. If set and clear occur in the same cycle, set wins.
- **Registers.** All registers are general purpose. Writing R0 is legal. A zero operand is available only via `op_alusrc1`.

## Timing
- **Reset.** While `reset` = 0:
  - state = IDLE; all registers, the op register and all outputs are 0, except `op_ready` = 1.
  - `op_valid` is ignored.
  - Memory contents are not reset.
- **Reset mid-operation.** The op is aborted with no register or memory write and no `res_valid`.
- **Latency, non-memory op:** accept at edge 0; READ, EXEC, WB in cycles 1–3; `res_valid` in cycle 3; R[rd] is visible from cycle 4; `op_ready` is high again in cycle 4.
- **Latency, memory op:** `res_valid` in cycle 4; `op_ready` is high in cycle 5.
- **Throughput:** 1 op per 4 (ALU) or 5 (memory) cycles.
- **Back-to-back.** `op_ready` = (state == IDLE) is combinational from state. A source holding `op_valid` high is accepted in the first IDLE cycle. Read-after-write is safe because the writeback completes before the next READ.

## Structure
- **Package `dp_pkg`:** `alu_op_e` (4-bit enum, values above), `dp_state_e` (IDLE, READ, EXEC, MEM, WB) and a packed `micro_op_t` struct of the captured fields.
- **Sub-module `dp_alu`:** combinational, parametrised by WIDTH, producing f, ovf and take_branch.
- **Top level:** the register file, memory array and FSM live in `alu_datamem_seq`.

## Test plan
- **Immediate load.** Reset, then ADD with alusrc1=1, alusrc2=1, imm=0x0005, rd=1, regwrite. Required: `res_valid` 3 cycles after accept, `res_data`=0x0005, then R1=5.
- **ADD overflow.** R1=0x7FFF; ADD R1 + imm 0x0001 → `res_data`=0x8000, `res_ovf`=1, `ovf_sticky`=1. Assert `clr_sticky` alone → 0. Assert `clr_sticky` together with another overflow → stays 1.
- **Store/load with wrap.** Store R2=0xBEEF at address 0x0103 (MEM_DEPTH=256), then load from 0x0003 into R3. Required: `res_data`=0xBEEF 4 cycles after accept; R3=0xBEEF.
- **Branch compare.** BEQ R1,R1 → `res_take_branch`=1, `res_data`=0, no register change. BNE R1,R1 → 0.
- **Handshake.** Hold `op_valid` high for 3 ops. Required: `op_ready` low during READ–WB; accepts exactly at cycles 0, 4, 8 for ALU ops; each op sees the previous op's writeback.
- **Reset abort.** Assert `reset` low during EXEC of a regwrite op to R4 (R4 = 0 from reset). Required: R4 stays 0, no `res_valid`, `op_ready`=1 after reset release.
